mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 32-bit memory port between two requesters: A (instruction fetch) and B (load/store).
//  - Round-robin arbitration with a req/done handshake.
//  - Address, write data and write enable are steered through an internal 2:1 select:
//    sel=1 routes A, sel=0 routes B.
//  - A watchdog aborts a transaction when the memory never answers.
//  Sits between the core datapath and the single-ported memory model.
// PARAMETERS
//  WIDTH    32  data/address width in bits
//  TIMEOUT  16  max BUSY cycles without mem_ready before abort (>=2); counter width clog2(TIMEOUT)
// PORTS
//  clk        input   1      rising-edge clock
//  rst        input   1      synchronous, active-high reset
//  req_a      input   1      A requests an access; held until done_a
//  addr_a     input   WIDTH  A address
//  wdata_a    input   WIDTH  A write data
//  we_a       input   1      A write enable
//  req_b      input   1      B requests an access; held until done_b
//  addr_b     input   WIDTH  B address
//  wdata_b    input   WIDTH  B write data
//  we_b       input   1      B write enable
//  gnt_a      output  1      A owns the port (BUSY or RESP with owner A)
//  gnt_b      output  1      B owns the port
//  done_a     output  1      1-cycle pulse: A transaction finished
//  done_b     output  1      1-cycle pulse: B transaction finished
//  err        output  1      qualifies done_x: transaction timed out
//  rdata      output  WIDTH  read data, registered, valid while done_x=1
//  mem_valid  output  1      access presented to memory
//  mem_addr   output  WIDTH  muxed address
//  mem_wdata  output  WIDTH  muxed write data
//  mem_we     output  1      muxed write enable, gated by mem_valid
//  mem_ready  input   1      memory completes the access this cycle
//  mem_rdata  input   WIDTH  memory read data, valid with mem_ready
// BEHAVIOUR
//  Reset (rst=1 at a clock edge, regardless of state):
//   - state=IDLE, owner=A, last=B (A wins the first tie), wait_cnt=0, rdata=0.
//   - All outputs 0.
//  State machine:
//   - IDLE -> BUSY:
//     - Only req_a: owner=A.
//     - Only req_b: owner=B.
//     - Both: owner = the requester that is not last.
//     - Neither: stay in IDLE.
//     - mem_ready is ignored in IDLE.
//   - BUSY:
//     - mem_valid=1; gnt of the owner=1.
//     - sel=(owner==A); mem_addr, mem_wdata and mem_we come combinationally from the owner's inputs.
//     - mem_ready=1 -> RESP: rdata<=mem_rdata (write: rdata<=0), err<=0, last<=owner.
//     - Else, if wait_cnt==TIMEOUT-1 -> RESP: rdata<=0, err<=1, last<=owner.
//     - Else wait_cnt++.
//   - RESP (1 cycle):
//     - done of the owner=1; gnt of the owner stays 1.
//     - mem_valid=0; req and mem_ready are ignored.
//     - Next state IDLE; wait_cnt<=0.
//     - err and rdata are held only this cycle and read 0 otherwise.
//  Latency:
//   - req seen at edge 0 -> BUSY from edge 0.
//   - mem_ready in the first BUSY cycle -> done in the next cycle.
//   - Minimum 3 cycles from request to next IDLE.
//   - Back-to-back throughput: one access per 3 cycles.
//  Handshake rules:
//   - The requester holds req, addr, wdata and we stable from assertion until its done pulse.
//   - It deasserts req at the edge ending the done cycle, unless it wants another access.
//   - If req is still high in IDLE, that is a new request.
//   - Dropping req during BUSY is a protocol violation; the transaction still completes normally.
//  Fairness:
//   - With both requesters continuously active, grants strictly alternate.
//   - A lone requester is re-granted every 3 cycles.
//  mem_we=0 whenever mem_valid=0; mem_addr and mem_wdata read 0 outside BUSY.
//  Reset mid-BUSY:
//   - The transaction is dropped, with no done and no err.
//   - Both requesters must re-request after reset.
// TESTING
//  1. rst high 2 cycles with req_a=req_b=1 -> all outputs 0; A granted on the first edge after rst falls.
//  2. A read 0x100, mem_ready 2 cycles after mem_valid, mem_rdata=0xDEADBEEF
//     -> mem_addr=0x100, mem_we=0, done_a one cycle later with rdata=0xDEADBEEF, err=0.
//  3. req_a=req_b=1 held for 4 transactions, mem_ready always 1
//     -> grant order A,B,A,B; done every 3 cycles; gnt_a and gnt_b never both 1.
//  4. B write addr=0x40, wdata=0x55 -> mem_we=1, mem_wdata=0x55 only during BUSY; done_b, rdata=0.
//  5. A request with mem_ready stuck 0, TIMEOUT=16 -> mem_valid high exactly 16 cycles;
//     done_a=1, err=1; next B request served normally.
//  6. rst asserted in the 3rd BUSY cycle of a B access -> IDLE, no done_b;
//     re-issued req_b completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (A) and load/store (B),
// with a watchdog that aborts a BUSY transaction the memory never answers.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_a_i,
  input  logic [WIDTH-1:0] addr_a_i,
  input  logic [WIDTH-1:0] wdata_a_i,
  input  logic             we_a_i,
  input  logic             req_b_i,
  input  logic [WIDTH-1:0] addr_b_i,
  input  logic [WIDTH-1:0] wdata_b_i,
  input  logic             we_b_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic             done_a_o,
  output logic             done_b_o,
  output logic             err_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             mem_valid_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic             mem_we_o,
  input  logic             mem_ready_i,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT);

  // IDLE: arbitrate | BUSY: access presented to memory | RESP: done pulse to the owner
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_a_q, owner_a_d;
  logic             last_a_q, last_a_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             sel;
  logic [WIDTH-1:0] addr_sel;
  logic [WIDTH-1:0] wdata_sel;
  logic             we_sel;

  assign sel       = owner_a_q;
  assign addr_sel  = sel ? addr_a_i  : addr_b_i;
  assign wdata_sel = sel ? wdata_a_i : wdata_b_i;
  assign we_sel    = sel ? we_a_i    : we_b_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      owner_a_q  <= 1'b1;
      last_a_q   <= 1'b0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_a_q  <= owner_a_d;
      last_a_q   <= last_a_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_a_d   = owner_a_q;
    last_a_d    = last_a_q;
    wait_cnt_d  = wait_cnt_q;
    rdata_d     = '0;
    err_d       = 1'b0;
    gnt_a_o     = 1'b0;
    gnt_b_o     = 1'b0;
    done_a_o    = 1'b0;
    done_b_o    = 1'b0;
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (req_a_i || req_b_i) begin
          state_d = S_BUSY;
          // On a tie the requester served last yields.
          if (req_a_i && req_b_i) owner_a_d = ~last_a_q;
          else                    owner_a_d = req_a_i;
        end
      end
      S_BUSY: begin
        gnt_a_o     = sel;
        gnt_b_o     = ~sel;
        mem_valid_o = 1'b1;
        mem_addr_o  = addr_sel;
        mem_wdata_o = wdata_sel;
        mem_we_o    = we_sel;
        if (mem_ready_i) begin
          state_d  = S_RESP;
          rdata_d  = we_sel ? '0 : mem_rdata_i;
          last_a_d = sel;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_RESP;
          err_d    = 1'b1;
          last_a_d = sel;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        gnt_a_o    = sel;
        gnt_b_o    = ~sel;
        done_a_o   = sel;
        done_b_o   = ~sel;
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // rdata/err are loaded only on the BUSY->RESP edge, so they read 0 outside RESP.
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// then protocol-legal random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_a, we_a, req_b, we_b, mem_ready;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b, mem_rdata;
  logic        gnt_a, gnt_b, done_a, done_b, err, mem_valid, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .req_b_i(req_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .done_a_o(done_a), .done_b_o(done_b),
    .err_o(err), .rdata_o(rdata),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  typedef struct packed {
    logic        gnt_a, gnt_b, done_a, done_b, err, mem_valid, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
  } outs_t;

  typedef struct {
    logic        rst, req_a, req_b, mem_ready;
    logic [31:0] mem_rdata;
    outs_t       exp;
  } vec_t;

  outs_t act;
  assign act = {gnt_a, gnt_b, done_a, done_b, err, mem_valid, mem_we, rdata, mem_addr, mem_wdata};

  function automatic outs_t eo(input logic ga, input logic gb, input logic da, input logic db,
                               input logic er, input logic mv, input logic mw,
                               input logic [31:0] rd, input logic [31:0] ma, input logic [31:0] md);
    eo = {ga, gb, da, db, er, mv, mw, rd, ma, md};
  endfunction

  function automatic vec_t mk(input logic r, input logic ra, input logic rb, input logic rdy,
                              input logic [31:0] mrd, input outs_t e);
    vec_t v;
    v.rst = r; v.req_a = ra; v.req_b = rb; v.mem_ready = rdy; v.mem_rdata = mrd; v.exp = e;
    return v;
  endfunction

  task automatic check_o(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_i(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Runs until the named requester sees done (dropping its req in that cycle) or the bound expires.
  task automatic run_txn(input bit is_a, input int bound, output int seen, output int e,
                         output int rd, output int nvalid);
    seen = 0; e = 0; rd = 0; nvalid = 0;
    for (int c = 0; c < bound && seen == 0; c++) begin
      #1;
      if (mem_valid) nvalid++;
      if (is_a ? done_a : done_b) begin
        seen = 1; e = int'(err); rd = int'(rdata);
        if (is_a) req_a = 1'b0; else req_b = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Transaction-level reference model state.
  int          m_phase;   // 0 no transaction, 1 access outstanding, 2 completion cycle
  int          m_owner;   // 0 = A, 1 = B
  int          m_last;
  int          m_busy;    // BUSY cycles spent by the current access
  logic [31:0] m_rdata;
  logic        m_err;

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t  vecs[11];
    outs_t z;
    outs_t exp;
    int    order[$];
    int    tdone[$];
    int    both_seen, seen, e, rd, nv, nbusy, saw_done, stall;

    z = '0;
    vecs[0]  = mk(1, 1, 1, 0, 32'h0,        z);
    vecs[1]  = mk(0, 1, 1, 0, 32'h0,        z);
    vecs[2]  = mk(0, 1, 1, 0, 32'h0,        eo(1,0,0,0,0,1,0, 32'h0, 32'h100, 32'h1234));
    vecs[3]  = mk(0, 1, 1, 0, 32'h0,        eo(1,0,0,0,0,1,0, 32'h0, 32'h100, 32'h1234));
    vecs[4]  = mk(0, 1, 1, 1, 32'hDEADBEEF, eo(1,0,0,0,0,1,0, 32'h0, 32'h100, 32'h1234));
    vecs[5]  = mk(0, 0, 1, 0, 32'h0,        eo(1,0,1,0,0,0,0, 32'hDEADBEEF, 32'h0, 32'h0));
    vecs[6]  = mk(0, 0, 1, 0, 32'h0,        z);
    vecs[7]  = mk(0, 0, 1, 1, 32'hCAFEF00D, eo(0,1,0,0,0,1,1, 32'h0, 32'h40, 32'h55));
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,        eo(0,1,0,1,0,0,0, 32'h0, 32'h0, 32'h0));
    vecs[9]  = mk(0, 0, 0, 1, 32'h11111111, z);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,        z);

    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    addr_a = 32'h100; wdata_a = 32'h1234; we_a = 1'b0;
    addr_b = 32'h40;  wdata_b = 32'h55;   we_b = 1'b1;
    @(posedge clk);

    // Directed table: reset, A read with delayed ready, B write, idle ignoring mem_ready.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req_a = vecs[i].req_a; req_b = vecs[i].req_b;
      mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
      #1 check_o($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Both requesters continuously active: strict alternation, one done per 3 cycles.
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; mem_ready = 1'b1;
    both_seen = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      #1;
      if (gnt_a && gnt_b) both_seen++;
      if (done_a) begin order.push_back(0); tdone.push_back(c); end
      if (done_b) begin order.push_back(1); tdone.push_back(c); end
      if (order.size() == 4) begin req_a = 1'b0; req_b = 1'b0; end
      @(negedge clk);
    end
    check_i("rr_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check_i($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, i % 2);
    for (int i = 1; i < 4; i++)
      check_i($sformatf("rr_gap%0d", i), (i < tdone.size()) ? tdone[i] - tdone[i-1] : -1, 3);
    check_i("rr_both_gnt", both_seen, 0);

    // Watchdog: memory never answers an A read.
    req_a = 1'b1; addr_a = 32'h200; we_a = 1'b0; mem_ready = 1'b0;
    run_txn(1'b1, 40, seen, e, rd, nv);
    check_i("to_done", seen, 1);
    check_i("to_err", e, 1);
    check_i("to_rdata", rd, 0);
    check_i("to_valid_cycles", nv, TIMEOUT);

    req_b = 1'b1; addr_b = 32'h300; we_b = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    run_txn(1'b0, 10, seen, e, rd, nv);
    check_i("after_to_done", seen, 1);
    check_i("after_to_err", e, 0);
    check_i("after_to_rdata", rd, int'(32'hA5A5A5A5));

    // Reset in the third BUSY cycle of a B access.
    req_b = 1'b1; addr_b = 32'h400; mem_ready = 1'b0;
    nbusy = 0; saw_done = 0;
    for (int c = 0; c < 20 && nbusy < 3; c++) begin
      #1;
      if (mem_valid) nbusy++;
      if (done_b) saw_done = 1;
      if (nbusy < 3) @(negedge clk);
    end
    check_i("rst_busy_reached", nbusy, 3);
    rst = 1'b1; req_b = 1'b0;
    @(negedge clk);
    #1 check_o("rst_mid_busy_outs", act, z);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      if (done_b) saw_done = 1;
      check_o($sformatf("rst_idle%0d", c), act, z);
    end
    check_i("rst_no_done", saw_done, 0);
    @(negedge clk);
    req_b = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h600DF00D;
    run_txn(1'b0, 10, seen, e, rd, nv);
    check_i("rst_reissue_done", seen, 1);
    check_i("rst_reissue_err", e, 0);
    check_i("rst_reissue_rdata", rd, int'(32'h600DF00D));

    // Random protocol-legal traffic against the reference model.
    stall = 0;
    m_phase = 0; m_owner = 0; m_last = 1; m_busy = 0; m_rdata = '0; m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = (n == 0) || ($urandom_range(0, 299) == 0);
      if (!req_a || (m_phase == 2 && m_owner == 0)) begin
        req_a = ($urandom_range(0, 99) < 60); addr_a = $urandom; wdata_a = $urandom;
        we_a = 1'($urandom_range(0, 1));
      end
      if (!req_b || (m_phase == 2 && m_owner == 1)) begin
        req_b = ($urandom_range(0, 99) < 60); addr_b = $urandom; wdata_b = $urandom;
        we_b = 1'($urandom_range(0, 1));
      end
      if (stall > 0) begin
        mem_ready = 1'b0; stall--;
      end else if ($urandom_range(0, 39) == 0) begin
        mem_ready = 1'b0; stall = 20;
      end else begin
        mem_ready = ($urandom_range(0, 2) == 0);
      end
      mem_rdata = $urandom;
      #1;
      exp = '0;
      if (m_phase == 1) begin
        exp.gnt_a     = (m_owner == 0);
        exp.gnt_b     = (m_owner == 1);
        exp.mem_valid = 1'b1;
        exp.mem_addr  = (m_owner == 0) ? addr_a  : addr_b;
        exp.mem_wdata = (m_owner == 0) ? wdata_a : wdata_b;
        exp.mem_we    = (m_owner == 0) ? we_a    : we_b;
      end else if (m_phase == 2) begin
        exp.gnt_a  = (m_owner == 0);
        exp.gnt_b  = (m_owner == 1);
        exp.done_a = (m_owner == 0);
        exp.done_b = (m_owner == 1);
        exp.err    = m_err;
        exp.rdata  = m_rdata;
      end
      check_o($sformatf("rand%0d", n), act, exp);

      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_owner = 0; m_last = 1; m_busy = 0; m_rdata = '0; m_err = 1'b0;
      end else if (m_phase == 0) begin
        if (req_a || req_b) begin
          if (req_a && req_b) m_owner = (m_last == 0) ? 1 : 0;
          else                m_owner = req_a ? 0 : 1;
          m_phase = 1; m_busy = 0;
        end
      end else if (m_phase == 1) begin
        m_busy++;
        if (mem_ready) begin
          m_phase = 2; m_err = 1'b0; m_last = m_owner;
          m_rdata = ((m_owner == 0) ? we_a : we_b) ? 32'h0 : mem_rdata;
        end else if (m_busy == TIMEOUT) begin
          m_phase = 2; m_err = 1'b1; m_last = m_owner; m_rdata = '0;
        end
      end else begin
        m_phase = 0; m_err = 1'b0; m_rdata = '0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
